varredura_display: RTL and testbench
====================================

VARREDURA_DISPLAY -- requirements
Module: varredura_display

Interface
REQ-001 Parameter N_DIG, default 4: number of multiplexed 7-segment digits, 2..8.
REQ-002 Parameter DIV, default 50000: clock cycles per digit slot, >= 2.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  1 = scan digits; 0 = display off.
REQ-006 load  input  1  single-cycle strobe; captures valor_in into the pending register.
REQ-007 valor_in  input  4*N_DIG  BCD digits; nibble k = digit k; digit 0 = least significant.
REQ-008 blank_zeros  input  1  1 = suppress leading zeros.
REQ-009 bcd_out  output  4  code for the shared downstream BCD-to-7-segment decoder; 4'hF = blank.
REQ-010 an_out  output  N_DIG  digit enables, active-low, one-hot-low or all ones.
REQ-011 pendente  output  1  1 = a loaded value is waiting for a frame boundary.

Function
REQ-012 A prescaler SHALL count 0..DIV-1, wrapping to 0; tick = (prescaler == DIV-1) in VARRENDO state.
REQ-013 A digit index idx SHALL count 0..N_DIG-1; it advances on tick and wraps N_DIG-1 -> 0.
REQ-014 FSM states: DESLIGADO, VARRENDO; DESLIGADO -> VARRENDO when enable=1; VARRENDO -> DESLIGADO when enable=0, effective next edge.
REQ-015 In DESLIGADO: prescaler=0, idx=0, an_out = all ones, bcd_out = 4'hF.
REQ-016 In VARRENDO: bcd_out = displayed nibble idx, or 4'hF if blanked; an_out[idx]=0, all other bits 1.
REQ-017 Dead time: an_out SHALL be all ones whenever prescaler == 0 in VARRENDO, to prevent ghosting; bcd_out stays valid.
REQ-018 bcd_out and an_out SHALL be combinational decodes of registered state (idx, prescaler, FSM, display register), with no extra latency.
REQ-019 load=1 SHALL write valor_in to the pending register and set pendente=1 on the next edge; last load wins if repeated.
REQ-020 Frame boundary = tick with idx == N_DIG-1; on it, if pendente=1, display register <= pending register and pendente <= 0.
REQ-021 Transition DESLIGADO -> VARRENDO with pendente=1 SHALL commit the pending value immediately on that edge.
REQ-022 If load coincides with a commit, the old pending value is committed, the new value becomes pending, and pendente stays 1.
REQ-023 Leading-zero blanking: digit k (k >= 1) is blanked when blank_zeros=1 and displayed digits k..N_DIG-1 are all 0; digit 0 is never blanked.
REQ-024 Nibbles > 9 SHALL be passed to bcd_out unchanged; the decoder blanks them.
REQ-025 load is accepted in both FSM states.

Reset
REQ-026 On rst=1 at an edge: FSM=DESLIGADO, prescaler=0, idx=0, display and pending registers=0, pendente=0; hence an_out = all ones and bcd_out = 4'hF.
REQ-027 rst SHALL take priority over load and enable in the same cycle; reset mid-frame discards the pending value.

Verification (N_DIG=4, DIV=4)
REQ-028 Reset, enable=1, load 16'h1234 -> after commit, the slot sequence shows bcd_out 4,3,2,1 with an_out 1110,1101,1011,0111, 4 cycles per slot; an_out=1111 in the first cycle of each slot.
REQ-029 During a frame showing 1234, load 16'h5678 at idx=1 -> pendente=1 until the tick at idx=3; the next frame shows 8,7,6,5; there is no mixed frame.
REQ-030 blank_zeros=1 with value 16'h0050 -> bcd_out F,F,5,0 for idx 3,2,1,0; value 16'h0000 -> only digit 0 shows 0.
REQ-031 enable dropped mid-slot -> next edge an_out=1111, bcd_out=F; re-enable -> the scan restarts at idx=0 with prescaler=0.
REQ-032 load in the same cycle as the frame-boundary commit -> the old pending value is displayed, the new value is pending, and pendente remains 1.
REQ-033 rst asserted mid-frame with pendente=1 -> next edge all outputs are at reset values and pendente=0.

Source files
------------

// File: rtl/varredura_display.sv
// Multiplexed 7-segment scanner: walks N_DIG digits, DIV clocks per slot,
// with a pending/display register pair so new values only appear at frame
// boundaries, leading-zero blanking and an anode dead time at slot start.
module varredura_display #(
  parameter int N_DIG = 4,
  parameter int DIV   = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 load,
  input  logic [4*N_DIG-1:0]   valor_in,
  input  logic                 blank_zeros,
  output logic [3:0]           bcd_out,
  output logic [N_DIG-1:0]     an_out,
  output logic                 pendente
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(N_DIG);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIG - 1);

  typedef enum logic {DESLIGADO, VARRENDO} state_t;

  state_t              state_reg, state_next;
  logic [PW-1:0]       prescaler_reg;
  logic [IW-1:0]       idx_reg;
  logic [4*N_DIG-1:0]  disp_reg;
  logic [4*N_DIG-1:0]  pend_reg;
  logic                pendente_reg;

  logic                tick;
  logic                start;
  logic                commit;
  logic [3:0]          nib   [N_DIG];
  logic [3:0]          shown [N_DIG];
  logic [N_DIG-1:0]    zero_from;
  logic [N_DIG-1:0]    an_sel;

  assign tick   = (state_reg == VARRENDO) && (prescaler_reg == PRE_MAX);
  assign start  = (state_reg == DESLIGADO) && enable;
  // Commit happens at the end of the last slot of a frame, or right away when
  // the scan starts so a value loaded while off is visible in the first frame.
  assign commit = pendente_reg && ((tick && (idx_reg == IDX_MAX)) || start);
  assign pendente = pendente_reg;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= DESLIGADO;
    else     state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DESLIGADO: if (enable)  state_next = VARRENDO;
      VARRENDO:  if (!enable) state_next = DESLIGADO;
      default:   state_next = DESLIGADO;
    endcase
  end

  // Scan counters and the pending/display register pair
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_reg <= '0;
      idx_reg       <= '0;
      disp_reg      <= '0;
      pend_reg      <= '0;
      pendente_reg  <= 1'b0;
    end else begin
      // Counters only run while scanning and staying on; any entry or exit
      // restarts the scan from slot 0, cycle 0.
      if ((state_reg == VARRENDO) && enable) begin
        prescaler_reg <= tick ? '0 : prescaler_reg + 1'b1;
        if (tick) idx_reg <= (idx_reg == IDX_MAX) ? '0 : idx_reg + 1'b1;
      end else begin
        prescaler_reg <= '0;
        idx_reg       <= '0;
      end
      if (commit) disp_reg <= pend_reg;
      if (load)   pend_reg <= valor_in;
      // A load coinciding with a commit keeps the flag set for the new value.
      pendente_reg <= load | (pendente_reg & ~commit);
    end
  end

  // Per-digit decode: nibble split, leading-zero run, blanking, anode select
  generate
    for (genvar gi = 0; gi < N_DIG; gi++) begin : g_dig
      assign nib[gi] = disp_reg[gi*4 +: 4];
      if (gi == N_DIG - 1) begin : g_top
        assign zero_from[gi] = (nib[gi] == 4'd0);
      end else begin : g_mid
        assign zero_from[gi] = (nib[gi] == 4'd0) && zero_from[gi+1];
      end
      if (gi == 0) begin : g_lsd
        assign shown[gi] = nib[gi];
      end else begin : g_upper
        assign shown[gi] = (blank_zeros && zero_from[gi]) ? 4'hF : nib[gi];
      end
      assign an_sel[gi] = (idx_reg == IW'(gi));
    end
  endgenerate

  // FSM outputs: blank when off, dead time on the first cycle of each slot
  always_comb begin
    bcd_out = 4'hF;
    an_out  = '1;
    if (state_reg == VARRENDO) begin
      bcd_out = shown[idx_reg];
      if (prescaler_reg != '0) an_out = ~an_sel;
    end
  end

endmodule

// File: tb/tb_varredura_display.sv
// Directed bench for varredura_display with N_DIG=4, DIV=4.
module tb_varredura_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] valor_in = '0;
  logic        blank_zeros = 1'b0;
  logic [3:0]  bcd_out;
  logic [3:0]  an_out;
  logic        pendente;

  int errors = 0;
  int checks = 0;

  varredura_display #(.N_DIG(4), .DIV(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load),
    .valor_in(valor_in), .blank_zeros(blank_zeros),
    .bcd_out(bcd_out), .an_out(an_out), .pendente(pendente)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Entered at the first cycle of a slot; checks all four cycles and
  // leaves at the first cycle of the following slot.
  task automatic slot(input string tag, input logic [3:0] eb, input logic [3:0] ea, input logic ep);
    for (int c = 0; c < 4; c++) begin
      chk({tag, "_bcd"}, {12'd0, bcd_out}, {12'd0, eb});
      chk({tag, "_an"},  {12'd0, an_out},  {12'd0, (c == 0) ? 4'hF : ea});
      chk({tag, "_pend"}, {15'd0, pendente}, {15'd0, ep});
      step();
    end
    $display("slot %s bcd=%h an=%b pend=%0d", tag, eb, ea, ep);
  endtask

  task automatic outs(input string tag, input logic [3:0] eb, input logic [3:0] ea, input logic ep);
    chk({tag, "_bcd"}, {12'd0, bcd_out}, {12'd0, eb});
    chk({tag, "_an"},  {12'd0, an_out},  {12'd0, ea});
    chk({tag, "_pend"}, {15'd0, pendente}, {15'd0, ep});
    $display("point %s bcd=%h an=%b pend=%0d", tag, bcd_out, an_out, pendente);
  endtask

  initial begin
    step_n(2);
    outs("reset", 4'hF, 4'hF, 1'b0);
    rst = 1'b0;

    // Load while off: pending, nothing displayed
    load = 1'b1; valor_in = 16'h1234; step(); load = 1'b0;
    outs("load_off", 4'hF, 4'hF, 1'b1);

    // Enable commits immediately; first frame shows 1234
    enable = 1'b1; step();
    slot("f1d0", 4'h4, 4'b1110, 1'b0);
    // Load 5678 at idx=1 first cycle
    outs("f1d1_p0", 4'h3, 4'hF, 1'b0);
    load = 1'b1; valor_in = 16'h5678; step(); load = 1'b0;
    outs("f1d1_p1", 4'h3, 4'b1101, 1'b1);
    step_n(3);
    slot("f1d2", 4'h2, 4'b1011, 1'b1);
    slot("f1d3", 4'h1, 4'b0111, 1'b1);
    // Next frame fully 5678
    slot("f2d0", 4'h8, 4'b1110, 1'b0);
    slot("f2d1", 4'h7, 4'b1101, 1'b0);
    slot("f2d2", 4'h6, 4'b1011, 1'b0);
    slot("f2d3", 4'h5, 4'b0111, 1'b0);

    // Frame 3: load 9012 at its start, then load 0050 on the boundary tick
    load = 1'b1; valor_in = 16'h9012; step(); load = 1'b0;
    outs("f3_load", 4'h8, 4'b1110, 1'b1);
    step_n(3 + 8 + 3);
    outs("f3d3_tick", 4'h5, 4'b0111, 1'b1);
    load = 1'b1; valor_in = 16'h0050; step(); load = 1'b0;
    slot("f4d0", 4'h2, 4'b1110, 1'b1);
    slot("f4d1", 4'h1, 4'b1101, 1'b1);
    slot("f4d2", 4'h0, 4'b1011, 1'b1);
    slot("f4d3", 4'h9, 4'b0111, 1'b1);

    // Frame 5: 0050 with leading-zero blanking
    blank_zeros = 1'b1;
    slot("f5d0", 4'h0, 4'b1110, 1'b0);
    slot("f5d1", 4'h5, 4'b1101, 1'b0);
    slot("f5d2", 4'hF, 4'b1011, 1'b0);
    slot("f5d3", 4'hF, 4'b0111, 1'b0);

    // Frame 6: load 0000, frame 7 shows only digit 0
    load = 1'b1; valor_in = 16'h0000; step(); load = 1'b0;
    outs("f6_load", 4'h0, 4'b1110, 1'b1);
    step_n(15);
    slot("f7d0", 4'h0, 4'b1110, 1'b0);
    slot("f7d1", 4'hF, 4'b1101, 1'b0);
    slot("f7d2", 4'hF, 4'b1011, 1'b0);
    slot("f7d3", 4'hF, 4'b0111, 1'b0);

    // Drop enable mid-slot (idx=1, prescaler=2)
    step_n(6);
    outs("mid_slot", 4'hF, 4'b1101, 1'b0);
    enable = 1'b0; step();
    outs("off", 4'hF, 4'hF, 1'b0);
    step_n(3);
    outs("off_hold", 4'hF, 4'hF, 1'b0);
    enable = 1'b1; step();
    outs("reen_p0", 4'h0, 4'hF, 1'b0);
    step();
    outs("reen_p1", 4'h0, 4'b1110, 1'b0);
    step_n(3);
    outs("reen_d1", 4'hF, 4'hF, 1'b0);

    // Reset mid-frame with a pending value, with load also asserted
    load = 1'b1; valor_in = 16'h1234; step(); load = 1'b0;
    outs("pend_before_rst", 4'hF, 4'b1101, 1'b1);
    rst = 1'b1; load = 1'b1; valor_in = 16'h4321; step();
    rst = 1'b0; load = 1'b0;
    outs("rst_mid", 4'hF, 4'hF, 1'b0);
    step();
    outs("after_rst_scan", 4'h0, 4'hF, 1'b0);
    step();
    outs("after_rst_p1", 4'h0, 4'b1110, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
